// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_SIZE data bits LSB first, optional even parity,
// STOP_BITS stop bits. Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx_serializer #(
   parameter int unsigned DATA_SIZE    = 7,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic [DATA_SIZE-1:0] d_i,
   input  logic                 tx_start,
   output logic                 tx_busy,
   output logic                 tx_o,
   output logic                 tx_done
);

   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW  = $clog2(DATA_SIZE + 1);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(DATA_SIZE - 1);
   localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e               state_q;
   logic [DATA_SIZE-1:0] shift_q;
   logic [DATA_SIZE-1:0] shift_nxt;
   logic [BaudW-1:0]     baud_q;
   logic [BitW-1:0]      bit_q;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   logic bit_end;
   logic frame_end;
   logic load;

   assign shift_nxt = shift_q >> 1;
   assign bit_end   = (baud_q == BaudLast);
   assign frame_end = (state_q == StStop) && bit_end && (bit_q == StopLast);
   // A start on the final stop edge chains the next frame with no idle gap and no busy drop.
   assign load      = tx_start && ((state_q == StIdle) || frame_end);

   always_ff @(posedge clk) begin
      if (res) begin
         state_q  <= StIdle;
         tx_o     <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         shift_q  <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         tx_done <= frame_end;
         if (load) begin
            state_q  <= StStart;
            shift_q  <= d_i;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_o     <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^d_i;
`endif
         end else if (frame_end) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_o    <= 1'b1;
            tx_busy <= 1'b0;
         end else if (state_q != StIdle) begin
            baud_q <= bit_end ? '0 : baud_q + 1'b1;
            if (bit_end) begin
               unique case (state_q)
                  StStart: begin
                     state_q <= StData;
                     tx_o    <= shift_q[0];
                  end
                  StData: begin
                     shift_q <= shift_nxt;
                     if (bit_q == DataLast) begin
                        bit_q <= '0;
`ifdef UART_TX_PARITY_EN
                        state_q <= StParity;
                        tx_o    <= parity_q;
`else
                        state_q <= StStop;
                        tx_o    <= 1'b1;
`endif
                     end else begin
                        bit_q <= bit_q + 1'b1;
                        tx_o  <= shift_nxt[0];
                     end
                  end
`ifdef UART_TX_PARITY_EN
                  StParity: begin
                     state_q <= StStop;
                     tx_o    <= 1'b1;
                  end
`endif
                  // Only non-final stop bits reach here; the final one is frame_end.
                  StStop: bit_q <= bit_q + 1'b1;
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

endmodule
